axi4lite_rr_master_arb: RTL

AXI4LITE_RR_MASTER_ARB -- requirements
Module: axi4lite_rr_master_arb

---
 rtl/axi4lite_rr_master_arb.sv | 138 +++++++++++++
 1 files changed

// File: rtl/axi4lite_rr_master_arb.sv
// axi4lite_rr_master_arb: two-requester round-robin front end driving one AXI4-Lite master port.
//   ACLK/ARESETn : clock, asynchronous active-low reset
//   req*         : per-requester request, direction, address, write data, strobes (requester i in slice i)
//   req_gnt      : one-cycle pulse when a request is accepted and latched
//   req_done     : one-cycle pulse when the granted transaction completes
//   req_rdata    : read data, valid from req_done and held until the next done
//   req_resp     : BRESP/RRESP of the last transaction, held until the next done
//   AW/W/B/AR/R  : AXI4-Lite master channels, one transaction outstanding at a time
module axi4lite_rr_master_arb #(
   parameter logic [2:0] AXPROT = 3'b000
) (
   input  logic        ACLK,
   input  logic        ARESETn,
   input  logic [1:0]  req,
   input  logic [1:0]  req_we,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   input  logic [7:0]  req_wstrb,
   output logic [1:0]  req_gnt,
   output logic [1:0]  req_done,
   output logic [31:0] req_rdata,
   output logic [1:0]  req_resp,
   output logic [31:0] AWADDR,
   output logic [2:0]  AWPROT,
   output logic        AWVALID,
   input  logic        AWREADY,
   output logic [31:0] WDATA,
   output logic [3:0]  WSTRB,
   output logic        WVALID,
   input  logic        WREADY,
   input  logic [1:0]  BRESP,
   input  logic        BVALID,
   output logic        BREADY,
   output logic [31:0] ARADDR,
   output logic [2:0]  ARPROT,
   output logic        ARVALID,
   input  logic        ARREADY,
   input  logic [31:0] RDATA,
   input  logic [1:0]  RRESP,
   input  logic        RVALID,
   output logic        RREADY
);
   typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R} state_t;
   state_t      state_q, state_d;
   logic        last_q, last_d, idx_q, idx_d, aw_q, aw_d, w_q, w_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic [1:0]  resp_q, resp_d;
   logic        sel, gnt, b_hs, r_hs;
   // last_q remembers the previous grant; on a tie the other requester wins.
   // Grants are gated by ARESETn so nothing pulses while reset is held.
   always_comb begin
      sel     = (req[0] & req[1]) ? ~last_q : req[1];
      gnt     = ARESETn && (state_q == IDLE) && (req != 2'b00);
      b_hs    = (state_q == WR_B) && BVALID;
      r_hs    = (state_q == RD_R) && RVALID;
      state_d = state_q;
      last_d  = last_q;
      idx_d   = idx_q;
      aw_d    = aw_q;
      w_d     = w_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      rdata_d = rdata_q;
      resp_d  = resp_q;
      case (state_q)
         IDLE: if (gnt) begin
            state_d = req_we[sel] ? WR_AW_W : RD_AR;
            last_d  = sel;
            idx_d   = sel;
            aw_d    = req_we[sel];
            w_d     = req_we[sel];
            addr_d  = sel ? req_addr[63:32] : req_addr[31:0];
            wdata_d = sel ? req_wdata[63:32] : req_wdata[31:0];
            wstrb_d = sel ? req_wstrb[7:4] : req_wstrb[3:0];
         end
         // aw_q/w_q are "still pending" flags; each channel retires on its own handshake
         WR_AW_W: begin
            aw_d = aw_q & ~AWREADY;
            w_d  = w_q & ~WREADY;
            if (!aw_d && !w_d) state_d = WR_B;
         end
         WR_B: if (BVALID) begin
            state_d = IDLE;
            resp_d  = BRESP;
         end
         RD_AR: if (ARREADY) state_d = RD_R;
         RD_R: if (RVALID) begin
            state_d = IDLE;
            rdata_d = RDATA;
            resp_d  = RRESP;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         idx_q   <= 1'b0;
         aw_q    <= 1'b0;
         w_q     <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         rdata_q <= '0;
         resp_q  <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         idx_q   <= idx_d;
         aw_q    <= aw_d;
         w_q     <= w_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         rdata_q <= rdata_d;
         resp_q  <= resp_d;
      end
   end
   // Response data is bypassed in the done cycle so it is valid together with req_done.
   assign req_gnt   = gnt ? (sel ? 2'b10 : 2'b01) : 2'b00;
   assign req_done  = (b_hs | r_hs) ? (idx_q ? 2'b10 : 2'b01) : 2'b00;
   assign req_rdata = r_hs ? RDATA : rdata_q;
   assign req_resp  = b_hs ? BRESP : r_hs ? RRESP : resp_q;
   assign AWADDR    = addr_q;
   assign ARADDR    = addr_q;
   assign WDATA     = wdata_q;
   assign WSTRB     = wstrb_q;
   assign AWPROT    = AXPROT;
   assign ARPROT    = AXPROT;
   assign AWVALID   = (state_q == WR_AW_W) && aw_q;
   assign WVALID    = (state_q == WR_AW_W) && w_q;
   assign BREADY    = (state_q == WR_B);
   assign ARVALID   = (state_q == RD_AR);
   assign RREADY    = (state_q == RD_R);
endmodule
